// File: rtl/divider_pkg.sv
// Shared constants, state encoding and sign helpers for the sequential divider.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef logic [1:0] div_state_t;

    localparam div_state_t IDLE = 2'd0;
    localparam div_state_t RUN  = 2'd1;
    localparam div_state_t FIX  = 2'd2;
    localparam div_state_t DONE = 2'd3;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [DIV_WIDTH-1:0] INT_MIN    = 32'h8000_0000;

    // Two's complement negate: invert and add one, wrapping on 32 bits.
    function automatic logic [DIV_WIDTH-1:0] neg32(input logic [DIV_WIDTH-1:0] x);
        return ~x + DIV_WIDTH'(1);
    endfunction

    // Unsigned magnitude; INT_MIN maps to 2^31 which still fits unsigned.
    function automatic logic [DIV_WIDTH-1:0] abs32(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract step: shifts a dividend bit into the partial remainder.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed only while the divider runs.
module div_step
    import divider_pkg::*;
#(
    parameter int W = DIV_WIDTH
) (
    input  logic [W-1:0] rem_i,
    input  logic         msb_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic         qbit_o
);

    logic [W:0] partial;
    logic [W:0] diff;

    // 33-bit compare so a 2^31 divisor magnitude is handled without overflow;
    // a clear sign bit on diff means the divisor fits and the quotient bit is 1.
    always_comb begin
        partial = {rem_i, msb_i};
        diff    = partial - {1'b0, dvs_i};
        qbit_o  = ~diff[W];
        rem_o   = qbit_o ? diff[W-1:0] : partial[W-1:0];
    end

endmodule

// File: rtl/divider.sv
// Sequential signed divider, one quotient bit per clock (restoring), results held until next start.
// Latency: 34 edges from accepting start to res_ok (32 RUN + FIX + accept); 1 edge for divide-by-zero.
// Backpressure: start is ignored while busy; no other flow control.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             res_ok,
    output logic             busy,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
    logic [WIDTH-1:0] dvd_q,      dvd_d;
    logic [WIDTH-1:0] dvs_q,      dvs_d;
    logic [WIDTH-1:0] rem_q,      rem_d;
    logic             qsign_q,    qsign_d;
    logic             rsign_q,    rsign_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quot_q,     quot_d;
    logic [WIDTH-1:0] remo_q,     remo_d;
    logic             res_ok_q,   res_ok_d;
    logic             dbz_q,      dbz_d;
    logic             ovf_q,      ovf_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    div_step #(
        .W (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .msb_i  (dvd_q[WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    // Next-state logic: accept start in IDLE/DONE, iterate in RUN, sign-correct in FIX.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        qsign_d    = qsign_q;
        rsign_d    = rsign_q;
        ovf_pend_d = ovf_pend_q;
        quot_d     = quot_q;
        remo_d     = remo_q;
        res_ok_d   = res_ok_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (opB == '0) begin
                        // Divide by zero short-circuits straight to a valid result.
                        state_d  = DONE;
                        quot_d   = DIV_ZERO_Q;
                        remo_d   = opA;
                        dbz_d    = 1'b1;
                        res_ok_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        cnt_d      = CNT_W'(WIDTH - 1);
                        dvd_d      = abs32(opA);
                        dvs_d      = abs32(opB);
                        rem_d      = '0;
                        qsign_d    = opA[WIDTH-1] ^ opB[WIDTH-1];
                        rsign_d    = opA[WIDTH-1];
                        ovf_pend_d = (opA == INT_MIN) && (opB == '1);
                        res_ok_d   = 1'b0;
                        dbz_d      = 1'b0;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (ovf_pend_q) begin
                    quot_d = INT_MIN;
                    remo_d = '0;
                end else begin
                    quot_d = qsign_q ? neg32(dvd_q) : dvd_q;
                    remo_d = rsign_q ? neg32(rem_q) : rem_q;
                end
                ovf_d    = ovf_pend_q;
                res_ok_d = 1'b1;
                state_d  = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            qsign_q    <= 1'b0;
            rsign_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            remo_q     <= '0;
            res_ok_q   <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            qsign_q    <= qsign_d;
            rsign_q    <= rsign_d;
            ovf_pend_q <= ovf_pend_d;
            quot_q     <= quot_d;
            remo_q     <= remo_d;
            res_ok_q   <= res_ok_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign res_ok      = res_ok_q;
    assign busy        = (state_q == RUN) || (state_q == FIX);
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the sequential divider with a scoreboard of expected results.
// Latency: checks 34-edge (or 1-edge divide-by-zero) completion and 33-cycle busy.
// Backpressure: exercises start being ignored while busy and accepted again in DONE.
module tb_divider;

    localparam logic [31:0] INT_MIN_C = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        res_ok;
    logic        busy;
    logic        div_by_zero;
    logic        overflow;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_q;
    logic [31:0] last_r;

    divider #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opA         (opA),
        .opB         (opB),
        .quotient    (quotient),
        .remainder   (remainder),
        .res_ok      (res_ok),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: native signed divide/modulo truncate toward zero, remainder follows dividend.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = '0;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (a == INT_MIN_C && b == 32'hFFFF_FFFF) begin
            e.q   = INT_MIN_C;
            e.r   = 32'd0;
            e.ovf = 1'b1;
        end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end
        return e;
    endfunction

    // Launch one divide, optionally pulse a new start with other operands at edge inj_at.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input logic [31:0] ia, input logic [31:0] ib);
        exp_t e;
        int   lat;
        int   busy_cnt;
        logic is_dbz;
        is_dbz = (b == 32'd0);
        opA    = a;
        opB    = b;
        start  = 1'b1;
        sb.push_back(model(a, b));
        tick();
        lat      = 1;
        busy_cnt = 0;
        start    = 1'b0;
        check({tag, ".accept_res_ok"}, 32'(res_ok), 32'(is_dbz));
        if (busy) busy_cnt++;
        while (!res_ok && lat < 60) begin
            if (lat == inj_at) begin
                opA   = ia;
                opB   = ib;
                start = 1'b1;
            end
            tick();
            lat++;
            start = 1'b0;
            if (busy) busy_cnt++;
        end
        check({tag, ".latency"}, 32'(lat), is_dbz ? 32'd1 : 32'd34);
        check({tag, ".busy_cycles"}, 32'(busy_cnt), is_dbz ? 32'd0 : 32'd33);
        e = sb.pop_front();
        check({tag, ".quotient"}, quotient, e.q);
        check({tag, ".remainder"}, remainder, e.r);
        check({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
        check({tag, ".overflow"}, 32'(overflow), 32'(e.ovf));
        last_q = e.q;
        last_r = e.r;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".quotient"}, quotient, 32'd0);
        check({tag, ".remainder"}, remainder, 32'd0);
        check({tag, ".res_ok"}, 32'(res_ok), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".div_by_zero"}, 32'(div_by_zero), 32'd0);
        check({tag, ".overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        start = 1'b0;
        opA   = 32'd0;
        opB   = 32'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        tick();

        run_op("pos_pos",  32'd100,       32'd7,        0, 32'd0, 32'd0);
        run_op("neg_pos",  32'hFFFF_FF9C, 32'd7,        0, 32'd0, 32'd0);
        run_op("pos_neg",  32'd100,       32'hFFFF_FFF9, 0, 32'd0, 32'd0);
        run_op("div_zero", 32'h1234_5678, 32'd0,        0, 32'd0, 32'd0);
        run_op("ovf",      INT_MIN_C,     32'hFFFF_FFFF, 0, 32'd0, 32'd0);
        run_op("min_by_1", INT_MIN_C,     32'd1,        0, 32'd0, 32'd0);
        run_op("min_min",  INT_MIN_C,     INT_MIN_C,    0, 32'd0, 32'd0);
        run_op("small_by_min", 32'd7,     INT_MIN_C,    0, 32'd0, 32'd0);
        run_op("neg_neg",  32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 32'd0, 32'd0);
        run_op("ignored_start", 32'd1000, 32'd3,        10, 32'd55, 32'd5);

        // Operand changes without start must not disturb a held result.
        opA = 32'hDEAD_BEEF;
        opB = 32'd17;
        repeat (5) tick();
        check("hold.res_ok", 32'(res_ok), 32'd1);
        check("hold.quotient", quotient, last_q);
        check("hold.remainder", remainder, last_r);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i[0]) rb = rb >> 20;
            if (rb == 32'd0) rb = 32'd3;
            run_op($sformatf("rand%0d", i), ra, rb, 0, 32'd0, 32'd0);
        end

        // Reset asserted between edges in the middle of RUN.
        opA   = 32'd5000;
        opB   = 32'd13;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("midrun.busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (40) tick();
        check("after_release.res_ok", 32'(res_ok), 32'd0);
        check("after_release.busy", 32'(busy), 32'd0);
        check("after_release.quotient", quotient, 32'd0);

        run_op("post_reset", 32'd5000, 32'd13, 0, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
